// File: rtl/cnt_ctrl_pkg.sv
// Shared op encodings, FSM states and counter step helpers.
// CNT_ARB_WRAP_STOP_EN adds the wrap-ahead predicate.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_INC1 = 2'b00,
        OP_INC2 = 2'b01,
        OP_DEC1 = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        CLR,
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [2:0] next_q(
        input logic [2:0] q,
        input op_e        op
    );
        unique case (op)
            OP_INC1: return q + 3'd1;
            OP_INC2: return q + 3'd2;
            OP_DEC1: return q - 3'd1;
            OP_CLR:  return 3'd0;
        endcase
    endfunction

`ifdef CNT_ARB_WRAP_STOP_EN
    function automatic logic would_wrap(
        input logic [2:0] q,
        input op_e        op
    );
        unique case (op)
            OP_INC1: return q == 3'd7;
            OP_INC2: return q >= 3'd6;
            OP_DEC1: return q == 3'd0;
            OP_CLR:  return 1'b0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/counter_arb_ctrl_if.sv
// Requester-side bundle of the counter arbiter controller.
// master = requester/bench side, slave = controller side.
interface counter_arb_ctrl_if #(
    parameter int LEN_W = 3
);
    logic [1:0]       req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [2:0]       done_q;
    logic             wrap_err;
    logic [2:0]       q;

    modport master (
        output req, op0, op1, len0, len1,
        input  gnt, busy, done, done_id,
        input  done_q, wrap_err, q
    );

    modport slave (
        input  req, op0, op1, len0, len1,
        output gnt, busy, done, done_id,
        output done_q, wrap_err, q
    );
endinterface

// File: rtl/counter_arb_ctrl_cnt.sv
// 3-bit modulo-8 counter driven by a 2-bit op select.
// No reset: sel=11 on the first edge clears it.
module counter_3bit
    import cnt_ctrl_pkg::*;
(
    input  logic       clk,
    input  op_e        sel,
    output logic [2:0] Q
);

    always_ff @(posedge clk) begin
        Q <= next_q(Q, sel);
    end

endmodule

// File: rtl/counter_arb_ctrl.sv
// Round-robin burst arbiter driving a counter_3bit.
// Define CNT_ARB_WRAP_STOP_EN to stop bursts before a wrap.
module counter_arb_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int LEN_W = 3
) (
    input logic               clk,
    input logic               rst_n,
    counter_arb_ctrl_if.slave bus
);

    state_e           state;
    op_e              op_r;
    op_e              sel;
    logic [LEN_W-1:0] len_r;
    logic             ptr;
    logic             win;
    logic             stop;
    logic [2:0]       q;
    logic [1:0]       gnt_r;
    logic             busy_r;
    logic             done_r;
    logic             id_r;
    logic [2:0]       dq_r;

`ifdef CNT_ARB_WRAP_STOP_EN
    logic werr_r;
    assign stop = (state == RUN)
                && would_wrap(q, op_r);
    assign bus.wrap_err = werr_r;
`else
    assign stop = 1'b0;
    assign bus.wrap_err = 1'b0;
`endif

    // ptr names the requester that wins a tie
    assign win = bus.req[1]
               & (~bus.req[0] | ptr);

    always_comb begin
        sel = OP_CLR;
        if (state == RUN && !stop)
            sel = op_r;
    end

    counter_3bit u_cnt (
        .clk (clk),
        .sel (sel),
        .Q   (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLR;
            gnt_r  <= 2'b00;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            id_r   <= 1'b0;
            dq_r   <= 3'd0;
            ptr    <= 1'b0;
            op_r   <= OP_INC1;
            len_r  <= '0;
`ifdef CNT_ARB_WRAP_STOP_EN
            werr_r <= 1'b0;
`endif
        end else begin
            gnt_r  <= 2'b00;
            done_r <= 1'b0;
`ifdef CNT_ARB_WRAP_STOP_EN
            werr_r <= 1'b0;
`endif
            unique case (state)
                CLR: state <= IDLE;
                IDLE: begin
                    if (|bus.req) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        gnt_r  <= win ? 2'b10
                                      : 2'b01;
                        id_r   <= win;
                        ptr    <= ~win;
                        op_r   <= op_e'(win ? bus.op1
                                            : bus.op0);
                        len_r  <= win ? bus.len1
                                      : bus.len0;
                    end
                end
                RUN: begin
                    if (stop || len_r == '0) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        // a stopped burst skips its step
                        dq_r   <= stop ? q
                                       : next_q(q, op_r);
`ifdef CNT_ARB_WRAP_STOP_EN
                        werr_r <= stop;
`endif
                    end else begin
                        len_r <= len_r - LEN_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.done_id = id_r;
    assign bus.done_q  = dq_r;
    assign bus.q       = q;

endmodule

// File: doc/counter_arb_ctrl.md
COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

Interface
REQ-001 Parameter: LEN_W, 3, width of burst-length field; burst length = len+1 steps, range 1..2^LEN_W.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-requester burst request; bit i belongs to requester i.
REQ-005 op0, op1  input  2 each  requested counter op: 00 +1, 01 +2, 10 -1, 11 clear.
REQ-006 len0, len1  input  LEN_W each  requested burst length minus one.
REQ-007 gnt  output  2  one-hot, single-cycle grant pulse.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  single-cycle end-of-burst pulse.
REQ-010 done_id  output  1  requester index of the completed burst, valid with done.
REQ-011 done_q  output  3  counter value at burst end, valid with done.
REQ-012 wrap_err  output  1  single-cycle pulse with done when a burst was stopped early; constant 0 without the macro.
REQ-013 q  output  3  live value of the internal counter_3bit.

Function
REQ-014 The FSM SHALL have four states: CLR, IDLE, RUN, DONE.
REQ-015 CLR: drive sel=11 for exactly one cycle, then go to IDLE.
REQ-016 IDLE: drive sel=11; if any req bit is high, pulse gnt for the winner, capture its op/len, and go to RUN on the same edge.
REQ-017 Arbitration SHALL be round-robin over 2 requesters: with both requesting, grant goes to the requester not granted last; after reset requester 0 has priority.
REQ-018 Requesters SHALL hold req/op/len until gnt; req sampled outside IDLE is ignored and not queued.
REQ-019 RUN: drive sel=captured op for exactly len+1 cycles, giving len+1 counter updates; then go to DONE.
REQ-020 DONE: drive sel=11; pulse done with done_id and done_q = q after the last step; go to IDLE next cycle.
REQ-021 Minimum gap between two grants SHALL be len+3 cycles: grant, RUN, DONE, IDLE.
REQ-022 Counter arithmetic is modulo 8; without the macro, wrap-around is silent.
REQ-023 Op 11 as a burst SHALL hold q at 0 for the burst duration and still complete with done.

Reset
REQ-024 rst_n low SHALL force state CLR, gnt=0, done=0, wrap_err=0, busy=0, done_id=0, done_q=0, RR pointer to requester 0, and captured op/len to 0, asynchronously.
REQ-025 sel SHALL be 11 while rst_n is low, so the counter clears on the first clk edge.
REQ-026 Reset during RUN SHALL abort the burst with no done pulse.

Configuration
REQ-027 CNT_ARB_WRAP_STOP_EN defined: RUN ends early, without applying the step, when the next step would wrap; that is op 00 at q=7, op 01 at q>=6, or op 10 at q=0.
REQ-028 With the macro defined, an early stop SHALL go to DONE and pulse wrap_err with done.
REQ-029 CNT_ARB_WRAP_STOP_EN undefined: no wrap check logic; wrap_err tied to 0.

Structure
REQ-030 Shared package cnt_ctrl_pkg SHALL hold the op encodings (OP_INC1, OP_INC2, OP_DEC1, OP_CLR) and the FSM state enum.
REQ-031 The existing counter_3bit SHALL be the single instantiated sub-module (clk, sel, Q); the arbiter and FSM stay inline.

Verification
REQ-032 Reset then req=01, op0=00, len0=3 -> gnt=01 one cycle, 4 steps q 1,2,3,4; done with done_id=0, done_q=4.
REQ-033 req=11 held from IDLE -> gnt=01 first; after requester 0's done, gnt=10; alternation continues.
REQ-034 Macro off, op1=01, len1=7 -> 8 steps of +2; done_q=0, wrap_err=0.
REQ-035 Macro on, op1=01, len1=7 -> q 2,4,6, stop; done_q=6, wrap_err=1 with done. Macro on, op0=10, len0=0 -> immediate stop, done_q=0, wrap_err=1.
REQ-036 rst_n low mid-RUN (q=3) -> outputs per REQ-024 immediately, no done; q=0 after the first edge; the next grant goes to requester 0.
